uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 49 ++++
 rtl/uart_tx_if.sv | 26 ++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/uart_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_tx.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding, baud divisor
//               table and select-to-divisor mapping used by TX and RX.
//               Optional parity state exists when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 14;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      , ST_PARITY = 3'd4
`endif
   } uart_state_e;

   // Divisor N gives a bit period of N+1 clocks at 100 MHz
   localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(10416);
   localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(5208);
   localparam logic [CNT_W-1:0] DIV_38400  = CNT_W'(2604);
   localparam logic [CNT_W-1:0] DIV_57600  = CNT_W'(1736);
   localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(868);
   localparam logic [CNT_W-1:0] DIV_230400 = CNT_W'(434);
   localparam logic [CNT_W-1:0] DIV_460800 = CNT_W'(217);
   localparam logic [CNT_W-1:0] DIV_921600 = CNT_W'(108);

   function automatic logic [CNT_W-1:0] baud_div(input logic [2:0] sel);
      case (sel)
         3'd1:    baud_div = DIV_19200;
         3'd2:    baud_div = DIV_38400;
         3'd3:    baud_div = DIV_57600;
         3'd4:    baud_div = DIV_115200;
         3'd5:    baud_div = DIV_230400;
         3'd6:    baud_div = DIV_460800;
         3'd7:    baud_div = DIV_921600;
         default: baud_div = DIV_9600;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_if
// Description : Byte-source valid/ready handshake into the UART transmitter.
//               Carries tx_parity_odd when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
   import uart_pkg::*;

   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_ready;
`ifdef UART_TX_PARITY_EN
   logic              tx_parity_odd;

   modport master (output tx_valid, output tx_data, output tx_parity_odd, input tx_ready);
   modport slave  (input tx_valid, input tx_data, input tx_parity_odd, output tx_ready);
`else
   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);
`endif

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter. Counts 0..div while run is high, flags
//               bit_end on the last count and wraps; held at 0 otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
   parameter int CNT_W = 14
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic [CNT_W-1:0] div,
   output logic [CNT_W-1:0] baud_cnt,
   output logic             bit_end
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear when stopped or at end of bit, else advance
   always_comb begin
      bit_end = run && (cnt_q == div);
      cnt_d   = cnt_q + 1'b1;
      if (!run || bit_end) begin
         cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign baud_cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, 8N1, LSB first, registered TX idling high.
//               Define UART_TX_PARITY_EN to insert a parity bit (8x1 frame).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 14
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       uart_en,
   input  logic [2:0] baud_tx_sel,
   uart_tx_if.slave   bus,
   output logic       TX,
   output logic       tx_busy,
   output logic       tx_done
);
   import uart_pkg::*;

   localparam int BIT_W = $clog2(DATA_W);

   uart_state_e       state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]  div_q, div_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   logic              accept;
   logic              run;
   logic              bit_end;
   // The raw count is not needed here; bit_end marks the boundary
   logic [CNT_W-1:0]  baud_cnt_unused;

   assign bus.tx_ready = uart_en && (state_q == ST_IDLE);
   assign accept       = bus.tx_valid && bus.tx_ready;
   // Dropping the enable also stops the counter so it clears with the FSM
   assign run          = uart_en && (state_q != ST_IDLE);

   uart_baud_gen #(.CNT_W(CNT_W)) u_baud (
      .clock    (clock),
      .reset    (reset),
      .run      (run),
      .div      (div_q),
      .baud_cnt (baud_cnt_unused),
      .bit_end  (bit_end)
   );

   // Next-state, shift/latch and registered-output logic
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      div_d     = div_q;
      done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      if (!uart_en) begin
         // Abort takes priority; any byte offered this cycle is dropped
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  shift_d = bus.tx_data;
                  div_d   = CNT_W'(baud_div(baud_tx_sel));
`ifdef UART_TX_PARITY_EN
                  par_d   = (^bus.tx_data) ^ bus.tx_parity_odd;
`endif
                  state_d = ST_START;
               end
            end
            ST_START: begin
               if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
               if (bit_end) begin
                  shift_d = shift_q >> 1;
                  if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                     bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                     state_d   = ST_PARITY;
`else
                     state_d   = ST_STOP;
`endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
               if (bit_end) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // TX is registered from where the FSM is heading, so it moves with the state
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = par_d;
`endif
         default:   tx_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         div_q     <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         div_q     <= div_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign TX      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Accepted bytes are queued as
//               expected frames and compared bit by bit as TX shifts them out.
//               Define UART_TX_PARITY_EN to exercise the parity frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

   logic       clock = 1'b0;
   logic       reset;
   logic       uart_en;
   logic [2:0] baud_tx_sel;
   logic       TX, tx_busy, tx_done;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int d0;

   // {parity_odd, byte} for every accepted byte, oldest first
   logic [8:0] exp_q[$];
   logic [8:0] dropped;

   uart_tx_if bus();

   uart_tx dut (
      .clock       (clock),
      .reset       (reset),
      .uart_en     (uart_en),
      .baud_tx_sel (baud_tx_sel),
      .bus         (bus.slave),
      .TX          (TX),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (tx_done === 1'b1) done_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Offer a byte at a negedge, wait for the accepting edge; returns at the
   // negedge of cycle k+1 (first cycle of the start bit)
   task automatic send(input logic [7:0] b, input logic odd, input bit hold);
      int n;
      n = 0;
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
`ifdef UART_TX_PARITY_EN
      bus.tx_parity_odd = odd;
`endif
      #1;
      while (bus.tx_ready !== 1'b1 && n < 30000) begin
         @(negedge clock);
         #1;
         n++;
      end
      check("accept_wait", (n < 30000), 1);
      @(negedge clock);
      exp_q.push_back({odd, b});
      if (!hold) begin
         bus.tx_valid = 1'b0;
         bus.tx_data  = 8'($urandom);
      end
   endtask

   // Compare first and last clock of every bit against the oldest queued byte;
   // returns at the cycle right after the frame (where tx_done must be high)
   task automatic check_frame(input int n, input string tag);
      logic [8:0]  e;
      logic [10:0] bits;
      int          nb;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 0, 1);
         return;
      end
      e = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
      nb   = 11;
      bits = {1'b1, (^e[7:0]) ^ e[8], e[7:0], 1'b0};
`else
      nb   = 10;
      bits = {1'b0, 1'b1, e[7:0], 1'b0};
`endif
      for (int i = 0; i < nb; i++) begin
         check($sformatf("%s_b%0d_tx_first", tag, i), TX, bits[i]);
         check($sformatf("%s_b%0d_busy", tag, i), tx_busy, 1);
         check($sformatf("%s_b%0d_ready", tag, i), bus.tx_ready, 0);
         tick(n);
         check($sformatf("%s_b%0d_tx_last", tag, i), TX, bits[i]);
         check($sformatf("%s_b%0d_nodone", tag, i), tx_done, 0);
         tick(1);
      end
      check({tag, "_done"}, tx_done, 1);
      check({tag, "_idle_tx"}, TX, 1);
      check({tag, "_idle_busy"}, tx_busy, 0);
   endtask

   initial begin
      reset        = 1'b1;
      uart_en      = 1'b0;
      baud_tx_sel  = 3'd7;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
`ifdef UART_TX_PARITY_EN
      bus.tx_parity_odd = 1'b0;
`endif
      tick(3);
      check("rst_tx", TX, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
      check("rst_ready_disabled", bus.tx_ready, 0);
      reset = 1'b0;
      tick(2);
      uart_en = 1'b1;
      #1;
      check("ready_enabled", bus.tx_ready, 1);
      check("idle_tx", TX, 1);
      tick(1);

      // Single frame at 921600
      send(8'hA5, 1'b0, 1'b0);
      check_frame(108, "a5");
      tick(3);

      // Back-to-back with tx_valid held: second start follows the done cycle
      send(8'h00, 1'b0, 1'b1);
      bus.tx_data = 8'hFF;
      check_frame(108, "b2b0");
      check("b2b_ready_at_done", bus.tx_ready, 1);
      tick(1);
      exp_q.push_back({1'b0, 8'hFF});
      bus.tx_valid = 1'b0;
      check_frame(108, "b2b1");
      tick(3);

      // Loopback-style decode at 115200
      baud_tx_sel = 3'd4;
      d0 = done_cnt;
      send(8'h55, 1'b0, 1'b0);
      check_frame(868, "lb55");
      send(8'h3C, 1'b0, 1'b0);
      check_frame(868, "lb3c");
      send(8'h81, 1'b0, 1'b0);
      check_frame(868, "lb81");
      tick(1);
      check("lb_done_count", done_cnt - d0, 3);

      // Baud select changed during a frame only affects the next frame
      baud_tx_sel = 3'd7;
      send(8'h5A, 1'b0, 1'b0);
      baud_tx_sel = 3'd0;
      check_frame(108, "selchg");
      tick(2);
      send(8'h01, 1'b0, 1'b0);
      check("slow_start_first", TX, 0);
      tick(10416);
      check("slow_start_last", TX, 0);
      tick(1);
      check("slow_bit0", TX, 1);
      uart_en = 1'b0;
      tick(1);
      check("slow_abort_tx", TX, 1);
      check("slow_abort_busy", tx_busy, 0);
      dropped = exp_q.pop_front();
      uart_en = 1'b1;
      baud_tx_sel = 3'd7;
      tick(2);

      // Abort during data bit 3
      send(8'hE7, 1'b0, 1'b0);
      tick(109 + 3 * 109 + 40);
      d0 = done_cnt;
      uart_en = 1'b0;
      #1;
      check("abort_ready_now", bus.tx_ready, 0);
      @(negedge clock);
      check("abort_tx", TX, 1);
      check("abort_busy", tx_busy, 0);
      check("abort_done", tx_done, 0);
      check("abort_ready", bus.tx_ready, 0);
      tick(200);
      check("abort_ready_held", bus.tx_ready, 0);
      check("abort_no_done", done_cnt - d0, 0);
      dropped = exp_q.pop_front();
      uart_en = 1'b1;
      #1;
      check("reen_ready", bus.tx_ready, 1);
      @(negedge clock);
      send(8'h12, 1'b0, 1'b0);
      check_frame(108, "reen12");
      tick(3);

      // Reset on the last clock of the stop bit
      send(8'h3C, 1'b0, 1'b0);
      tick(9 * 109 + 108);
      check("pre_rst_tx", TX, 1);
      check("pre_rst_busy", tx_busy, 1);
      reset = 1'b1;
      #1;
      check("async_rst_busy", tx_busy, 0);
      check("async_rst_tx", TX, 1);
      check("async_rst_done", tx_done, 0);
      @(negedge clock);
      check("rst_hold_done", tx_done, 0);
      check("rst_hold_busy", tx_busy, 0);
      reset = 1'b0;
      dropped = exp_q.pop_front();
      tick(3);

`ifdef UART_TX_PARITY_EN
      // Even data parity with odd=0 yields a 1 parity bit for 0x07
      send(8'h07, 1'b0, 1'b0);
      check_frame(108, "par07");
      tick(2);
`endif

      check("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
